// File: rtl/ppc_seven_segment_display_if.sv
// Signal bundle between the ping-pong counter side and the seven-segment
// display stage: counter value/direction/blank in, digit enables and
// segment drives out.
interface ppc_seven_segment_display_if;
  logic [3:0] value;
  logic       direction;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;

  // master: the side feeding the display (counter / bench)
  modport master (
    output value,
    output direction,
    output blank,
    input  an,
    input  seg
  );

  // slave: the display stage itself
  modport slave (
    input  value,
    input  direction,
    input  blank,
    output an,
    output seg
  );
endinterface

// File: rtl/ppc_seven_segment_display.sv
// Four-digit time-multiplexed seven-segment driver for the ping-pong counter.
// Digits 3..2 show the counter value in decimal (leading zero blanked),
// digits 1..0 show a direction glyph. Inputs are captured once per scan frame
// so a frame is always self-consistent. an/seg are registered.
module ppc_seven_segment_display #(
  parameter int REFRESH_DIV = 17,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic                          clk,
  input logic                          rst_n,
  ppc_seven_segment_display_if.slave   disp
);

  // Active-high glyph patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_UP   = 7'h23;
  localparam logic [6:0] GLYPH_DOWN = 7'h1C;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;
  localparam logic [6:0] GLYPH_ONE  = 7'h06;

  localparam logic [REFRESH_DIV-1:0] CNT_ONE = {{(REFRESH_DIV-1){1'b0}}, 1'b1};
  localparam logic [REFRESH_DIV-1:0] CNT_MAX = {REFRESH_DIV{1'b1}};

  // Fully-off drive levels depend on panel polarity
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [REFRESH_DIV-1:0] cnt;
  logic [1:0]             idx;
  logic [3:0]             snap_val;
  logic                   snap_dir;
  logic                   tick;

  logic [3:0]             ones_val;
  logic [6:0]             pattern;
  logic [3:0]             onehot;

  // Decimal digit to segment pattern; anything outside 0..9 renders blank
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = GLYPH_OFF;
    endcase
    return g;
  endfunction

  assign tick = (cnt == CNT_MAX);

  // Select the content of the digit currently addressed by idx
  always_comb begin
    ones_val = (snap_val >= 4'd10) ? (snap_val - 4'd10) : snap_val;
    pattern  = GLYPH_OFF;
    onehot   = 4'b0000;
    case (idx)
      2'd3: begin
        onehot  = 4'b1000;
        pattern = (snap_val >= 4'd10) ? GLYPH_ONE : GLYPH_OFF;
      end
      2'd2: begin
        onehot  = 4'b0100;
        pattern = digit_glyph(ones_val);
      end
      2'd1: begin
        onehot  = 4'b0010;
        pattern = snap_dir ? GLYPH_UP : GLYPH_DOWN;
      end
      default: begin
        onehot  = 4'b0001;
        pattern = snap_dir ? GLYPH_UP : GLYPH_DOWN;
      end
    endcase
  end

  // Refresh divider, scan index and once-per-frame input snapshot.
  // Blank does not pause any of this, so the snapshot still lands when a
  // frame boundary falls inside a blanked window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= 2'd0;
      snap_val <= 4'd0;
      snap_dir <= 1'b1;
    end else begin
      cnt <= cnt + CNT_ONE;
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_val <= disp.value;
          snap_dir <= disp.direction;
        end
      end
    end
  end

  // Registered panel drive: one cycle behind idx/snapshot/blank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp.an  <= AN_OFF;
      disp.seg <= SEG_OFF;
    end else if (disp.blank) begin
      disp.an  <= AN_OFF;
      disp.seg <= SEG_OFF;
    end else begin
      disp.an  <= ACTIVE_LOW ? ~onehot  : onehot;
      disp.seg <= ACTIVE_LOW ? ~pattern : pattern;
    end
  end

endmodule

// File: tb/tb_ppc_seven_segment_display.sv
// Bench for ppc_seven_segment_display (REFRESH_DIV=2, active-low panel).
// A behavioural model predicts {an,seg} for every clock; predictions go into
// exp_q when inputs are applied and are popped after the edge that produces
// them. Directed frame checks use hand-written active-low constants.
module tb_ppc_seven_segment_display;

  localparam int W = 11;

  logic clk;
  logic rst_n;

  ppc_seven_segment_display_if dif ();

  ppc_seven_segment_display #(
    .REFRESH_DIV (2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (dif.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // model state
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_val = 4'd0;
  logic       m_dir = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Prediction of the panel drive for the model's current state and inputs
  function automatic logic [W-1:0] predict();
    logic [6:0] pat;
    logic [3:0] oh;
    oh = 4'b0001 << m_idx;
    if (m_idx == 3)      pat = (m_val > 4'd9) ? 7'h06 : 7'h00;
    else if (m_idx == 2) pat = ref_glyph(m_val % 10);
    else                 pat = m_dir ? 7'h23 : 7'h1C;
    if (!rst_n || dif.blank) return {4'hF, 7'h7F};
    return {~oh, ~pat};
  endfunction

  // One clock: predict, advance model, let the DUT clock, pop and compare
  task automatic cyc(input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(predict());
      if (!rst_n) begin
        m_cnt = 0; m_idx = 0; m_val = 4'd0; m_dir = 1'b1;
      end else begin
        if (m_cnt == 3) begin
          if (m_idx == 3) begin
            m_val = dif.value;
            m_dir = dif.direction;
          end
          m_idx = (m_idx + 1) % 4;
        end
        m_cnt = (m_cnt + 1) % 4;
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb", {21'd0, dif.an, dif.seg}, {21'd0, e});
      end
    end
  endtask

  // Direct check of the current outputs against hand-derived constants
  task automatic look(input string tag, input logic [3:0] a, input logic [6:0] s);
    check({tag, "_an"},  {28'd0, dif.an},  {28'd0, a});
    check({tag, "_seg"}, {25'd0, dif.seg}, {25'd0, s});
  endtask

  // Walk one whole frame starting at its first cycle (idx0 shown)
  task automatic check_frame(input string tag, input logic [6:0] tens,
                             input logic [6:0] ones, input logic [6:0] dirg);
    cyc(1); look({tag, "_d0"}, 4'hE, dirg);
    cyc(4); look({tag, "_d1"}, 4'hD, dirg);
    cyc(4); look({tag, "_d2"}, 4'hB, ones);
    cyc(4); look({tag, "_d3"}, 4'h7, tens);
    cyc(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    dif.value     = 4'd13;
    dif.direction = 1'b0;
    dif.blank     = 1'b0;

    // reset held for two cycles
    cyc(2);
    look("reset", 4'hF, 7'h7F);
    rst_n = 1'b1;

    // frame 1: snapshot still at reset values (blank tens, "0", UP)
    check_frame("f1", 7'h7F, 7'h40, 7'h5C);
    // frame 2 shows 13 DOWN; new inputs ignored until the boundary
    dif.value = 4'd7; dif.direction = 1'b1;
    check_frame("f2", 7'h79, 7'h30, 7'h63);
    // frame 3 shows 7 UP with blank tens
    dif.value = 4'd9;
    check_frame("f3", 7'h7F, 7'h78, 7'h5C);

    // frame 4: value changes 9 -> 4 while idx=1, frame keeps showing 9
    cyc(1); look("f4_d0", 4'hE, 7'h5C);
    cyc(4); look("f4_d1", 4'hD, 7'h5C);
    dif.value = 4'd4;
    cyc(4); look("f4_d2", 4'hB, 7'h10);
    cyc(4); look("f4_d3", 4'h7, 7'h7F);
    cyc(3);
    check_frame("f5", 7'h7F, 7'h19, 7'h5C);

    // frame 6: blank for 6 cycles mid-frame, then resume on idx2
    cyc(2);
    dif.blank = 1'b1;
    cyc(1); look("blank_a", 4'hF, 7'h7F);
    cyc(5); look("blank_b", 4'hF, 7'h7F);
    dif.blank = 1'b0;
    cyc(1); look("unblank", 4'hB, 7'h19);
    // blank straddling the frame boundary: snapshot of 15 still taken
    dif.value = 4'd15;
    cyc(5);
    dif.blank = 1'b1;
    cyc(3); look("blank_tick", 4'hF, 7'h7F);
    dif.blank = 1'b0;
    cyc(4); look("f7_d1", 4'hD, 7'h5C);
    cyc(4); look("f7_d2", 4'hB, 7'h12);
    cyc(4); look("f7_d3", 4'h7, 7'h79);
    cyc(3);

    // value 10
    dif.value = 4'd10;
    check_frame("f8", 7'h79, 7'h12, 7'h5C);
    check_frame("f9", 7'h79, 7'h40, 7'h5C);

    // reset for one cycle while idx2 shows 12
    dif.value = 4'd12;
    check_frame("f10", 7'h79, 7'h40, 7'h5C);
    cyc(9); look("f11_d2", 4'hB, 7'h24);
    cyc(1);
    rst_n = 1'b0;
    cyc(1); look("midreset", 4'hF, 7'h7F);
    rst_n = 1'b1;
    check_frame("f12", 7'h7F, 7'h40, 7'h5C);
    check_frame("f13", 7'h79, 7'h24, 7'h5C);

    // sweep every 4-bit value with alternating direction (model checked)
    for (int v = 0; v < 16; v++) begin
      dif.value     = v[3:0];
      dif.direction = v[0];
      cyc(16);
    end

    // random inputs, occasional blank and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) dif.value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dif.direction = 1'($urandom_range(0, 1));
      dif.blank = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppc_seven_segment_display.md
Name: ppc_seven_segment_display

Overview:
Downstream display stage for the parameterized ping-pong counter. It consumes the counter's 4-bit `out` and `direction` and drives a 4-digit, time-multiplexed seven-segment display.
- Digits 3..2: counter value in decimal (0..15).
- Digits 1..0: a direction glyph.
- Inputs are snapshotted once per scan frame, so a frame never mixes old and new values.

Parameters:
REFRESH_DIV, 17, width of the refresh counter; the scan advances one digit every 2^REFRESH_DIV clk cycles (the bench uses 2).
ACTIVE_LOW, 1, 1 = an/seg are active-low (board default); 0 = active-high.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
value  input  4  counter value (ping-pong counter `out`)
direction  input  1  1 = counting up, 0 = counting down
blank  input  1  1 = turn every digit off (scanning continues)
an  output  4  digit enables; an[k] selects digit k (3 = leftmost)
seg  output  7  segments {g,f,e,d,c,b,a}, seg[0] = a

Behaviour:
- Active-high glyph patterns {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - UP = 23 (a,b,f), DOWN = 1C (c,d,e), OFF = 00
  - When ACTIVE_LOW=1, seg = ~pattern and an = ~onehot.
- Refresh counter `cnt`:
  - REFRESH_DIV bits, increments every cycle and wraps.
  - tick = (cnt == all ones).
- Scan index `idx` (2 bits):
  - Advances 0→1→2→3→0 on tick; each digit is held for 2^REFRESH_DIV cycles.
- Snapshot:
  - On a tick with idx==3 (frame boundary), `snap_val <= value` and `snap_dir <= direction`.
  - Input changes at any other time are ignored until the next boundary.
- Digit content, by idx:
  - idx3: tens digit; "1" if snap_val>=10, else OFF (leading-zero blanking).
  - idx2: ones digit, snap_val mod 10.
  - idx1, idx0: UP if snap_dir=1, else DOWN.
- Outputs are registered:
  - an/seg reflect the current idx/snapshot/blank with exactly 1 cycle latency.
  - Exactly one digit is enabled per cycle unless blanked or in reset.
- blank=1: an and seg are all off on the next cycle. cnt, idx and snapshot keep running. Deasserting blank resumes on whatever digit idx currently holds.
- Reset (rst_n=0 at a clk edge), including mid-frame:
  - cnt=0, idx=0, snap_val=0, snap_dir=1 (matches the counter's reset direction).
  - an=all off (4'b1111 when active-low), seg=all off (7'h7F when active-low).
- First cycle after reset release: an=1110, seg shows UP (7'h5C).
- Boundary cases:
  - value=15 shows "15".
  - value=10 shows "10".
  - value=0 shows blank tens and "0".
  - blank and frame tick in the same cycle: the snapshot is still taken.
  - No undefined states: every 4-bit value is mapped.

Test Plan (REFRESH_DIV=2, ACTIVE_LOW=1; each digit lasts 4 cycles, each frame 16 cycles):
1. Hold rst_n=0 for 2 cycles, then release → during reset an=1111, seg=7F; first post-reset cycle an=1110, seg=5C; an=1101 from cycle 5; 1011 from cycle 9; 0111 from cycle 13.
2. value=13, direction=0 from reset; after the first frame boundary → an=0111/seg=79, an=1011/seg=30, an=1101 and 1110/seg=63 (DOWN).
3. value=7, direction=1 → tens digit an=0111 with seg=7F (blanked); ones digit seg=78; direction digits seg=5C.
4. value changed 9→4 while idx=1 → rest of the frame still shows 9 (seg=10); new value seen only after the idx3→0 tick (seg=19 at idx2 of the next frame).
5. blank=1 for 6 cycles mid-frame → an=1111, seg=7F from the following cycle; idx keeps advancing; after release an matches the expected idx after 1 cycle.
6. rst_n=0 for 1 cycle while idx=2 showing value=12 → next cycle an=1111, seg=7F; after release scanning restarts at an=1110 with the snapshot cleared (tens blank, ones "0", UP) until the next frame boundary.
